// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC predictor.
package pc_pkg;

  // 2-bit saturating branch direction counter
  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'b00;
  localparam ctr_t WEAK_NT   = 2'b01;
  localparam ctr_t WEAK_T    = 2'b10;
  localparam ctr_t STRONG_T  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;

  // Saturating step toward taken / not-taken; never wraps past the ends.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken) return (c == STRONG_T) ? c : c + 2'd1;
    return (c == STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is purely combinational on the current fetch PC; updates are
// written on the clock edge, so a same-index lookup sees old contents.
module btb
  import pc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc_i,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             upd_taken_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  ctr_t               ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic             ctr_wr, alloc, tgt_wr;
  ctr_t             ctr_wdata;

  // Byte-offset bits never take part in index or tag.
  logic unused_lsb;
  assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[WIDTH-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[WIDTH-1:IDX_W+2];

  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_o = tgt_q[lk_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Decide what the resolved branch writes: train on hit, allocate on taken miss.
  always_comb begin
    ctr_wr    = 1'b0;
    alloc     = 1'b0;
    tgt_wr    = 1'b0;
    ctr_wdata = ctr_q[upd_idx];
    if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_wr    = 1'b1;
        ctr_wdata = ctr_next(ctr_q[upd_idx], upd_taken_i);
        tgt_wr    = upd_taken_i;
      end else if (upd_taken_i) begin
        ctr_wr    = 1'b1;
        ctr_wdata = WEAK_T;
        alloc     = 1'b1;
        tgt_wr    = 1'b1;
      end
    end
  end

  // Valid bits and counters: reset so a fresh BTB never predicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else begin
      if (alloc)  valid_q[upd_idx] <= 1'b1;
      if (ctr_wr) ctr_q[upd_idx]   <= ctr_wdata;
    end
  end

  // Tag and target payload: unreset, only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (alloc)  tag_q[upd_idx] <= upd_tag;
    if (tgt_wr) tgt_q[upd_idx] <= upd_target_i;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction.
// Next-PC priority: redirect > stall > predicted target > PC+4.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               BTB_ENTRIES  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken,
  output logic [WIDTH-1:0] PC,
  output logic             pred_taken
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pred_target;

  btb #(
    .WIDTH   (WIDTH),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_target_i  (upd_target),
    .upd_taken_i   (upd_taken)
  );

  // Next-PC select; sequential fetch wraps naturally at the top of the space.
  always_comb begin
    pc_d = pc_q + WIDTH'(4);
    if (redirect)        pc_d = redirect_pc;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

  localparam int N  = 16;
  localparam int SH = $clog2(N) + 2;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, PC;
  logic        pred_taken;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays of what each BTB slot holds.
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  pc_predict_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .PC          (PC),
    .pred_taken  (pred_taken)
  );

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit m_pred(logic [31:0] a);
    int i;
    i = idx_of(a);
    return m_valid[i] && (m_tag[i] == (a >> SH)) && (m_ctr[i] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_pc = 32'h0;
  endtask

  task automatic m_edge();
    logic [31:0] nxt;
    int i;
    if (redirect)          nxt = redirect_pc;
    else if (stall)        nxt = m_pc;
    else if (m_pred(m_pc)) nxt = m_tgt[idx_of(m_pc)];
    else                   nxt = m_pc + 32'd4;
    if (upd_valid) begin
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == (upd_pc >> SH)) begin
        if (upd_taken) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = upd_target;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upd_pc >> SH;
        m_tgt[i]   = upd_target;
        m_ctr[i]   = 2;
      end
    end
    m_pc = nxt;
  endtask

  task automatic drive(bit st, bit rd, logic [31:0] rpc,
                       bit uv, logic [31:0] upc, logic [31:0] utg, bit utk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_target  = utg;
    upd_taken   = utk;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
  endtask

  // One clock: advance the model alongside the DUT and compare after the edge.
  task automatic step(string name);
    @(posedge clk);
    m_edge();
    #1;
    n_vec++;
    if (PC !== m_pc) begin
      n_err++;
      $display("FAIL %s PC got %h want %h", name, PC, m_pc);
    end
    n_vec++;
    if (pred_taken !== m_pred(m_pc)) begin
      n_err++;
      $display("FAIL %s pred_taken got %b want %b (PC %h)", name, pred_taken, m_pred(m_pc), m_pc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] seq [3];
    seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC;
    idle();
    rst = 1'b1;
    m_reset();
    #2;
    n_vec++;
    if (PC !== 32'h0 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got PC=%h pred=%b want PC=00000000 pred=0", PC, pred_taken);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("free_run");
      n_vec++;
      if (PC !== seq[i] || pred_taken !== 1'b0) begin
        n_err++;
        $display("FAIL free_run_seq got PC=%h pred=%b want PC=%h pred=0", PC, pred_taken, seq[i]);
      end
    end
  endtask

  task automatic test_alloc();
    drive(0, 0, 32'h0, 1, 32'h10, 32'h40, 1);
    step("alloc");
    idle();
    n_vec++;
    if (PC !== 32'h10 || pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL alloc_hit got PC=%h pred=%b want PC=00000010 pred=1", PC, pred_taken);
    end
    step("alloc_follow");
    n_vec++;
    if (PC !== 32'h40) begin
      n_err++;
      $display("FAIL alloc_target got %h want 00000040", PC);
    end
  endtask

  task automatic test_train_down();
    drive(0, 0, 32'h0, 1, 32'h10, 32'h0, 0);
    step("train_nt1");
    step("train_nt2");
    drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
    step("train_redir");
    idle();
    n_vec++;
    if (PC !== 32'h10 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL train_down got PC=%h pred=%b want PC=00000010 pred=0", PC, pred_taken);
    end
    step("train_seq");
    n_vec++;
    if (PC !== 32'h14) begin
      n_err++;
      $display("FAIL train_down_next got %h want 00000014", PC);
    end
  endtask

  task automatic test_stall_redirect();
    drive(1, 1, 32'h100, 0, 32'h0, 32'h0, 0);
    step("stall_redir");
    n_vec++;
    if (PC !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_over_stall got %h want 00000100", PC);
    end
    drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      step("stall_hold");
      n_vec++;
      if (PC !== 32'h100) begin
        n_err++;
        $display("FAIL stall_hold got %h want 00000100", PC);
      end
    end
    idle();
  endtask

  task automatic test_wrap_and_async_reset();
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    step("wrap_redir");
    idle();
    step("wrap");
    n_vec++;
    if (PC !== 32'h0) begin
      n_err++;
      $display("FAIL wrap got %h want 00000000", PC);
    end
    step("pre_reset");
    #2;
    drive(0, 0, 32'h0, 1, 32'h20, 32'h80, 1);
    rst = 1'b1;
    #1;
    n_vec++;
    if (PC !== 32'h0 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got PC=%h pred=%b want PC=00000000 pred=0", PC, pred_taken);
    end
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    step("post_reset");
    n_vec++;
    if (PC !== 32'h4) begin
      n_err++;
      $display("FAIL post_reset got %h want 00000004", PC);
    end
    for (int i = 0; i < 7; i++) step("post_reset_run");
    n_vec++;
    if (PC !== 32'h20 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard got PC=%h pred=%b want PC=00000020 pred=0", PC, pred_taken);
    end
  endtask

  task automatic test_alias();
    drive(0, 0, 32'h0, 1, 32'h10, 32'h40, 1);
    step("alias_a");
    drive(0, 0, 32'h0, 1, 32'h50, 32'h200, 1);
    step("alias_b");
    drive(0, 1, 32'h10, 0, 32'h0, 32'h0, 0);
    step("alias_redir_a");
    idle();
    n_vec++;
    if (PC !== 32'h10 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL alias_evicted got PC=%h pred=%b want PC=00000010 pred=0", PC, pred_taken);
    end
    drive(0, 1, 32'h50, 0, 32'h0, 32'h0, 0);
    step("alias_redir_b");
    idle();
    n_vec++;
    if (pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL alias_new got pred=%b want 1", pred_taken);
    end
    step("alias_follow");
    n_vec++;
    if (PC !== 32'h200) begin
      n_err++;
      $display("FAIL alias_target got %h want 00000200", PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc, upc, utg;
    for (int i = 0; i < 400; i++) begin
      rpc = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      if ($urandom % 20 == 0) rpc = 32'hFFFF_FFFC;
      upc = {22'h0, 8'($urandom_range(0, 63)), 2'($urandom)};
      if ($urandom % 8 == 0) upc[31:28] = 4'($urandom);
      utg = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      drive($urandom % 8 == 0, $urandom % 10 == 0, rpc,
            $urandom % 3 == 0, upc, utg, $urandom % 2 == 1);
      step("random");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_train_down();
    test_stall_redirect();
    test_wrap_and_async_reset();
    test_alias();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
